// File: rtl/accel_cmp_pkg.sv
// Shared definitions for the OFM compare engine: FSM state codes, read-latency
// bounds, counter widths and the saturating error-count adder.
package accel_cmp_pkg;

   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] ST_ISSUE  = 2'd1;
   localparam logic [STATE_W-1:0] ST_DRAIN  = 2'd2;
   localparam logic [STATE_W-1:0] ST_FINISH = 2'd3;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   localparam int SIZE_W  = 9;
   localparam int NFILT_W = 11;
   localparam int TOTAL_W = 2 * SIZE_W + NFILT_W;
   localparam int ERR_W   = 16;

   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                 input logic [ERR_W-1:0] inc);
      logic [ERR_W:0] sum;
      sum = {1'b0, acc} + {1'b0, inc};
      return sum[ERR_W] ? ERR_MAX : sum[ERR_W-1:0];
   endfunction

endpackage

// File: rtl/ofm_lane_cmp.sv
// Per-lane compare of one OFM word against its golden word, with lane masking,
// mismatch popcount and lowest mismatching lane. OFM_CMP_TOLERANCE_EN selects
// magnitude-tolerant compare instead of exact bitwise compare.
module ofm_lane_cmp
   import accel_cmp_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 16,
   parameter int CNT_W      = $clog2(LANES + 1),
   parameter int LIDX_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic [LANES*DATA_WIDTH-1:0] ofm_word,
   input  logic [LANES*DATA_WIDTH-1:0] gold_word,
   input  logic [LANES-1:0]            lane_mask,
   input  logic [DATA_WIDTH-1:0]       tolerance,
   output logic [CNT_W-1:0]            mism_cnt,
   output logic [LIDX_W-1:0]           low_lane
);

   logic [LANES-1:0] raw;
   logic [LANES-1:0] mism;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      assign a = ofm_word[g*DATA_WIDTH +: DATA_WIDTH];
      assign b = gold_word[g*DATA_WIDTH +: DATA_WIDTH];
`ifdef OFM_CMP_TOLERANCE_EN
      // One extra bit so the signed difference can never overflow.
      logic signed [DATA_WIDTH:0] diff;
      logic        [DATA_WIDTH:0] mag;
      assign diff   = $signed({a[DATA_WIDTH-1], a}) - $signed({b[DATA_WIDTH-1], b});
      assign mag    = diff[DATA_WIDTH] ? (~diff + 1'b1) : diff;
      assign raw[g] = mag > {1'b0, tolerance};
`else
      assign raw[g] = (a != b);
`endif
   end

`ifndef OFM_CMP_TOLERANCE_EN
   logic unused_tol;
   assign unused_tol = ^tolerance;
`endif

   assign mism = raw & lane_mask;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      mism_cnt = '0;
      low_lane = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         mism_cnt = mism_cnt + CNT_W'(mism[i]);
         if (mism[i]) low_lane = LIDX_W'(i);
      end
   end

endmodule

// File: rtl/ofm_compare_engine.sv
// Streams an OFM RAM and a golden RAM word by word, counts mismatching elements
// and records the first one. Build option: OFM_CMP_TOLERANCE_EN (tolerant compare).
module ofm_compare_engine
   import accel_cmp_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 16,
   parameter int ADDR_WIDTH = 20,
   parameter int RD_LATENCY = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic                        done,
   output logic                        busy,
   input  logic [SIZE_W-1:0]           ofm_size,
   input  logic [NFILT_W-1:0]          num_filter,
   input  logic                        stop_on_err,
   output logic                        ofm_rd_en,
   output logic [ADDR_WIDTH-1:0]       ofm_rd_addr,
   input  logic [LANES*DATA_WIDTH-1:0] ofm_rd_data,
   output logic                        gold_rd_en,
   output logic [ADDR_WIDTH-1:0]       gold_rd_addr,
   input  logic [LANES*DATA_WIDTH-1:0] gold_rd_data,
   output logic                        pass,
   output logic [ERR_W-1:0]            err_count,
   output logic [ADDR_WIDTH+7:0]       first_err_idx,
   input  logic [DATA_WIDTH-1:0]       tolerance
);

   localparam int CNT_W  = $clog2(LANES + 1);
   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int IDX_W  = ADDR_WIDTH + 8;

   if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_lat_check
      $error("ofm_compare_engine: RD_LATENCY must be within 1..4");
   end

   logic [STATE_W-1:0]    state_q, state_d;
   logic [TOTAL_W-1:0]    words_q, issue_cnt_q;
   logic [LIDX_W-1:0]     rem_q;
   logic                  stop_q;
   logic [DATA_WIDTH-1:0] tol_q;

   logic [RD_LATENCY-1:0] pipe_vld_q;
   logic [LANES-1:0]      pipe_mask_q [RD_LATENCY];
   logic [ADDR_WIDTH-1:0] pipe_addr_q [RD_LATENCY];

   logic                  cmp_vld_q;
   logic [CNT_W-1:0]      cmp_cnt_q;
   logic [LIDX_W-1:0]     cmp_lane_q;
   logic [ADDR_WIDTH-1:0] cmp_addr_q;

   logic [ERR_W-1:0]      err_q, err_d;
   logic [IDX_W-1:0]      first_idx_q;
   logic                  found_q, pass_q;

   logic [TOTAL_W-1:0]    total_in, words_in;
   logic [LIDX_W-1:0]     rem_in;
   logic                  start_acc, last_word, stop_hit, issue, pipe_busy;
   logic [LANES-1:0]      issue_mask, cmp_mask;
   logic [CNT_W-1:0]      lane_cnt;
   logic [LIDX_W-1:0]     lane_low;

   assign total_in  = TOTAL_W'(ofm_size) * TOTAL_W'(ofm_size) * TOTAL_W'(num_filter);
   assign words_in  = (total_in + TOTAL_W'(LANES - 1)) / TOTAL_W'(LANES);
   assign rem_in    = LIDX_W'(total_in % TOTAL_W'(LANES));
   assign start_acc = (state_q == ST_IDLE) && start;
   assign last_word = (issue_cnt_q == words_q - TOTAL_W'(1));
   assign stop_hit  = stop_q && cmp_vld_q && (cmp_cnt_q != '0);
   assign issue     = (state_q == ST_ISSUE) && !stop_hit;
   assign pipe_busy = (|pipe_vld_q) || cmp_vld_q;
   assign err_d     = cmp_vld_q ? sat_add(err_q, ERR_W'(cmp_cnt_q)) : err_q;

   // Only the final word of a ragged pass carries invalid upper lanes.
   always_comb begin
      issue_mask = '1;
      if (last_word && rem_q != '0) begin
         for (int i = 0; i < LANES; i++) begin
            if (i >= int'(rem_q)) issue_mask[i] = 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = (total_in == '0) ? ST_DRAIN : ST_ISSUE;
         ST_ISSUE:  if (stop_hit) state_d = ST_FINISH;
                    else if (last_word) state_d = ST_DRAIN;
         ST_DRAIN:  if (stop_hit || !pipe_busy) state_d = ST_FINISH;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign cmp_mask = pipe_vld_q[RD_LATENCY-1] ? pipe_mask_q[RD_LATENCY-1] : '0;

   ofm_lane_cmp #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .CNT_W      (CNT_W),
      .LIDX_W     (LIDX_W)
   ) u_lane_cmp (
      .ofm_word  (ofm_rd_data),
      .gold_word (gold_rd_data),
      .lane_mask (cmp_mask),
      .tolerance (tol_q),
      .mism_cnt  (lane_cnt),
      .low_lane  (lane_low)
   );

   // NOTE: sequential state uses non-blocking assignment; a later assignment in
   // this block (e.g. the flush on stop) deliberately overrides an earlier one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         words_q     <= '0;
         issue_cnt_q <= '0;
         rem_q       <= '0;
         stop_q      <= 1'b0;
         tol_q       <= '0;
         pipe_vld_q  <= '0;
         // NOTE: the pipeline arrays are tiny flop stages, so they are reset
         // alongside the valid bits rather than left as uninitialised storage.
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_mask_q[i] <= '0;
            pipe_addr_q[i] <= '0;
         end
         cmp_vld_q   <= 1'b0;
         cmp_cnt_q   <= '0;
         cmp_lane_q  <= '0;
         cmp_addr_q  <= '0;
         err_q       <= '0;
         first_idx_q <= '0;
         found_q     <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         pipe_vld_q[0]  <= issue;
         pipe_mask_q[0] <= issue_mask;
         pipe_addr_q[0] <= ADDR_WIDTH'(issue_cnt_q);
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_mask_q[i] <= pipe_mask_q[i-1];
            pipe_addr_q[i] <= pipe_addr_q[i-1];
         end
         cmp_vld_q  <= pipe_vld_q[RD_LATENCY-1];
         cmp_cnt_q  <= lane_cnt;
         cmp_lane_q <= lane_low;
         cmp_addr_q <= pipe_addr_q[RD_LATENCY-1];
         if (stop_hit) begin
            pipe_vld_q <= '0;
            cmp_vld_q  <= 1'b0;
         end
         if (start_acc) begin
            words_q     <= words_in;
            rem_q       <= rem_in;
            stop_q      <= stop_on_err;
            tol_q       <= tolerance;
            issue_cnt_q <= '0;
            err_q       <= '0;
            first_idx_q <= '0;
            found_q     <= 1'b0;
            pass_q      <= 1'b0;
         end else begin
            if (issue) issue_cnt_q <= issue_cnt_q + TOTAL_W'(1);
            err_q <= err_d;
            if (cmp_vld_q && cmp_cnt_q != '0 && !found_q) begin
               found_q     <= 1'b1;
               first_idx_q <= IDX_W'(cmp_addr_q) * IDX_W'(LANES) + IDX_W'(cmp_lane_q);
            end
            if (state_d == ST_FINISH && state_q != ST_FINISH) pass_q <= (err_d == '0);
         end
      end
   end

   assign done          = (state_q == ST_FINISH);
   assign busy          = (state_q != ST_IDLE);
   assign ofm_rd_en     = issue;
   assign gold_rd_en    = issue;
   assign ofm_rd_addr   = ADDR_WIDTH'(issue_cnt_q);
   assign gold_rd_addr  = ADDR_WIDTH'(issue_cnt_q);
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_idx = first_idx_q;

endmodule

// File: tb/tb_ofm_compare_engine.sv
// Self-checking bench for ofm_compare_engine: two latency-accurate RAM models and
// an element-level reference model of the comparison result.
module tb_ofm_compare_engine;

   localparam int DW   = 16;
   localparam int LN   = 16;
   localparam int AW   = 20;
   localparam int LAT  = 3;
   localparam int MAXE = 131072;
   localparam int LOGN = 8192;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stop_on_err = 1'b0;
   logic [8:0]    ofm_size = '0;
   logic [10:0]   num_filter = '0;
   logic [DW-1:0] tolerance = '0;

   logic             done, busy, pass;
   logic             ofm_rd_en, gold_rd_en;
   logic [AW-1:0]    ofm_rd_addr, gold_rd_addr;
   logic [LN*DW-1:0] ofm_rd_data, gold_rd_data;
   logic [15:0]      err_count;
   logic [AW+7:0]    first_err_idx;

   logic [DW-1:0] ofm_el  [MAXE];
   logic [DW-1:0] gold_el [MAXE];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ofm_compare_engine #(
      .DATA_WIDTH (DW),
      .LANES      (LN),
      .ADDR_WIDTH (AW),
      .RD_LATENCY (LAT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .done          (done),
      .busy          (busy),
      .ofm_size      (ofm_size),
      .num_filter    (num_filter),
      .stop_on_err   (stop_on_err),
      .ofm_rd_en     (ofm_rd_en),
      .ofm_rd_addr   (ofm_rd_addr),
      .ofm_rd_data   (ofm_rd_data),
      .gold_rd_en    (gold_rd_en),
      .gold_rd_addr  (gold_rd_addr),
      .gold_rd_data  (gold_rd_data),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .tolerance     (tolerance)
   );

   // RAM models: data for a read appears LAT cycles later; otherwise the two
   // buses carry different junk so a wrongly timed sample shows up as errors.
   logic [LAT-1:0] ov_q, gv_q;
   logic [AW-1:0]  oa_q [LAT];
   logic [AW-1:0]  ga_q [LAT];

   always @(posedge clk) begin
      ov_q[0] <= ofm_rd_en;
      oa_q[0] <= ofm_rd_addr;
      gv_q[0] <= gold_rd_en;
      ga_q[0] <= gold_rd_addr;
      for (int i = 1; i < LAT; i++) begin
         ov_q[i] <= ov_q[i-1];
         oa_q[i] <= oa_q[i-1];
         gv_q[i] <= gv_q[i-1];
         ga_q[i] <= ga_q[i-1];
      end
   end

   always_comb begin
      ofm_rd_data  = '0;
      gold_rd_data = '0;
      for (int l = 0; l < LN; l++) begin
         ofm_rd_data[l*DW +: DW]  = ov_q[LAT-1] ? ofm_el[(int'(oa_q[LAT-1]) * LN + l) % MAXE] : 16'hFFFF;
         gold_rd_data[l*DW +: DW] = gv_q[LAT-1] ? gold_el[(int'(ga_q[LAT-1]) * LN + l) % MAXE] : 16'h0000;
      end
   end

   // Read-bus monitor: logs every read address and counts ofm/gold disagreement.
   int            rd_total = 0;
   int            sync_err = 0;
   logic [AW-1:0] rd_log [LOGN];

   always @(posedge clk) begin
      if (ofm_rd_en || gold_rd_en) begin
         if (ofm_rd_en !== gold_rd_en || ofm_rd_addr !== gold_rd_addr) sync_err <= sync_err + 1;
         rd_log[rd_total % LOGN] <= ofm_rd_addr;
         rd_total <= rd_total + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit el_bad(input int e, input logic [DW-1:0] tol);
`ifdef OFM_CMP_TOLERANCE_EN
      int d;
      d = int'($signed(ofm_el[e])) - int'($signed(gold_el[e]));
      if (d < 0) d = -d;
      return d > int'({1'b0, tol});
`else
      bit unused_t;
      unused_t = ^tol;
      return ofm_el[e] != gold_el[e];
`endif
   endfunction

   // Reference: walk elements in order; with stop, only the first bad word counts.
   task automatic model(input int total, input bit stp, input logic [DW-1:0] tol,
                        output int e_err, output int e_first, output int e_fw);
      int cnt;
      cnt     = 0;
      e_fw    = -1;
      e_first = 0;
      for (int e = 0; e < total; e++) begin
         if (el_bad(e, tol)) begin
            if (e_fw < 0) begin
               e_fw    = e / LN;
               e_first = e;
            end
            if (!stp || e / LN == e_fw) cnt++;
         end
      end
      e_err = (cnt > 65535) ? 65535 : cnt;
   endtask

   // Elements inside the pass match; everything beyond it differs.
   task automatic fill(input int total);
      for (int e = 0; e < MAXE; e++) begin
         ofm_el[e]  = DW'($urandom);
         gold_el[e] = (e < total) ? ofm_el[e] : ~ofm_el[e];
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, ":done"}, done, 0);
      check({tag, ":busy"}, busy, 0);
      check({tag, ":pass"}, pass, 0);
      check({tag, ":err"}, err_count, 0);
      check({tag, ":first"}, first_err_idx, 0);
      check({tag, ":ofm_en"}, ofm_rd_en, 0);
      check({tag, ":gold_en"}, gold_rd_en, 0);
      check({tag, ":ofm_addr"}, ofm_rd_addr, 0);
      check({tag, ":gold_addr"}, gold_rd_addr, 0);
   endtask

   task automatic run_pass(input string tag, input int sz, input int nf, input bit stp,
                           input logic [DW-1:0] tol, input int poke_at);
      int total, words, e_err, e_first, e_fw, base, sbase, n, nr;
      bit seen, seq_ok;
      total = sz * sz * nf;
      words = (total + LN - 1) / LN;
      model(total, stp, tol, e_err, e_first, e_fw);
      @(negedge clk);
      base        = rd_total;
      sbase       = sync_err;
      ofm_size    = 9'(sz);
      num_filter  = 11'(nf);
      stop_on_err = stp;
      tolerance   = tol;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n     = 1;
      seen  = 1'b0;
      check({tag, ":busy"}, busy, 1);
      while (!seen && n < 20000) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            start = (poke_at != 0 && n == poke_at);
            if (start) begin
               ofm_size    = 9'd5;
               num_filter  = 11'd7;
               stop_on_err = ~stp;
            end
            @(negedge clk);
            n++;
         end
      end
      start = 1'b0;
      check({tag, ":done_seen"}, seen, 1);
      if (total == 0) check({tag, ":done_lat"}, n, 2);
      check({tag, ":err"}, err_count, e_err);
      check({tag, ":pass"}, pass, e_err == 0);
      check({tag, ":first"}, first_err_idx, e_first);
      nr = rd_total - base;
      if (!stp || e_fw < 0) check({tag, ":reads"}, nr, words);
      else check({tag, ":reads_win"}, (nr >= e_fw + 1) && (nr <= e_fw + LAT + 2), 1);
      seq_ok = 1'b1;
      for (int i = 0; i < nr; i++) begin
         if (rd_log[(base + i) % LOGN] != AW'(i)) seq_ok = 1'b0;
      end
      check({tag, ":addr_seq"}, seq_ok, 1);
      check({tag, ":rd_sync"}, sync_err - sbase, 0);
      @(negedge clk);
      check({tag, ":done_pulse"}, done, 0);
      check({tag, ":idle"}, busy, 0);
      check({tag, ":hold_err"}, err_count, e_err);
   endtask

   initial begin
      int dcnt;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;

      fill(10140);
      run_pass("eq", 26, 15, 0, 0, 5);

      gold_el[500] = ofm_el[500] + 16'd3;
      run_pass("off3", 26, 15, 0, 0, 0);
      run_pass("off3_tol", 26, 15, 0, 3, 0);

      fill(10140);
      gold_el[40]   = ofm_el[40] ^ 16'h0010;
      gold_el[9000] = ofm_el[9000] ^ 16'h8000;
      run_pass("stop", 26, 15, 1, 0, 0);

      fill(10140);
      gold_el[633*LN + 13] = ofm_el[633*LN + 13] ^ 16'h0001;
      run_pass("masked", 26, 15, 0, 0, 0);

      run_pass("nf0", 26, 0, 0, 0, 1);

      fill(10140);
      gold_el[40] = ofm_el[40] ^ 16'h0100;
      @(negedge clk);
      ofm_size    = 9'd26;
      num_filter  = 11'd15;
      stop_on_err = 1'b0;
      tolerance   = '0;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      check("abort:pre_err", err_count, 1);
      check("abort:pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset("abort");
      dcnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("abort:no_done", dcnt, 0);
      rst_n = 1'b1;
      run_pass("post_rst", 26, 15, 0, 0, 0);

      fill(69632);
      for (int e = 0; e < 69632; e++) gold_el[e] = ~ofm_el[e];
      run_pass("sat", 64, 17, 0, 0, 0);

      for (int k = 0; k < 6; k++) begin
         int sz, nf, total, nm;
         sz    = $urandom_range(1, 12);
         nf    = $urandom_range(1, 6);
         total = sz * sz * nf;
         fill(total);
         nm = $urandom_range(0, 4);
         for (int j = 0; j < nm; j++) begin
            int e;
            e = $urandom_range(0, total - 1);
            gold_el[e] = ofm_el[e] + DW'($urandom_range(1, 9));
         end
         run_pass($sformatf("rand%0d", k), sz, nf, 1'($urandom_range(0, 1)),
                  DW'($urandom_range(0, 6)), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ofm_compare_engine.md
OFM_COMPARE_ENGINE -- requirements
Module: ofm_compare_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning bits per OFM element (signed two's complement).
REQ-002 SHALL have parameter LANES, default 16, meaning elements per RAM word (INOUT_WIDTH/DATA_WIDTH).
REQ-003 SHALL have parameter ADDR_WIDTH, default 20, meaning word-address width of both read ports.
REQ-004 SHALL have parameter RD_LATENCY, default 1, meaning RAM read latency in cycles (legal 1..4).
REQ-005 SHALL have ports: clk input 1, system clock; rst_n input 1, reset (one clock; reset is asynchronous and active-low).
REQ-006 SHALL have ports: start input 1, begin pass; done output 1, one-cycle completion pulse; busy output 1, pass in progress.
REQ-007 SHALL have ports: ofm_size input 9, OFM height/width; num_filter input 11, OFM channel count; stop_on_err input 1, halt at first mismatch.
REQ-008 SHALL have ports: ofm_rd_en output 1; ofm_rd_addr output ADDR_WIDTH; ofm_rd_data input LANES*DATA_WIDTH (DUT OFM RAM).
REQ-009 SHALL have ports: gold_rd_en output 1; gold_rd_addr output ADDR_WIDTH; gold_rd_data input LANES*DATA_WIDTH (golden RAM).
REQ-010 SHALL have ports: pass output 1; err_count output 16; first_err_idx output ADDR_WIDTH+8 (element index); tolerance input DATA_WIDTH (used only per REQ-026).

Function
REQ-011 SHALL latch ofm_size, num_filter, stop_on_err, tolerance on accepted start; total = ofm_size*ofm_size*num_filter elements, words = ceil(total/LANES).
REQ-012 SHALL accept start only in IDLE; start while busy ignored, no state change.
REQ-013 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> FINISH -> IDLE.
REQ-014 ISSUE: assert ofm_rd_en and gold_rd_en together, identical address, incrementing by 1 from 0 each cycle until words-1 issued, then DRAIN.
REQ-015 SHALL carry a RD_LATENCY-deep valid/lane-mask pipeline; returned data sampled exactly RD_LATENCY cycles after its read.
REQ-016 Compare stage SHALL register per-lane mismatch one cycle after data returns; DRAIN exits when pipeline and compare stage empty.
REQ-017 Last word SHALL mask lanes >= total mod LANES (when nonzero); masked lanes never mismatch.
REQ-018 err_count SHALL add popcount of mismatching lanes per word, saturating at 16'hFFFF.
REQ-019 first_err_idx SHALL capture word_addr*LANES + lowest mismatching lane of the first mismatching word only.
REQ-020 stop_on_err=1: first mismatch SHALL stop further issue, discard in-flight results, err_count = mismatching lanes of that word only, go to FINISH.
REQ-021 FINISH: done=1 one cycle, pass=(err_count==0), return IDLE; pass/err_count/first_err_idx hold until next accepted start clears them.
REQ-022 total=0: ISSUE SHALL be skipped, done pulses 2 cycles after start, pass=1.
REQ-023 busy SHALL be 1 from cycle after accepted start through FINISH inclusive.

Reset
REQ-024 rst_n low SHALL force IDLE, all outputs 0 (pass 0, err_count 0, first_err_idx 0, rd_en 0, addresses 0), clear pipeline; asserting mid-pass aborts without done.
REQ-025 First start after reset release SHALL behave identically to any other.

Configuration
REQ-026 With OFM_CMP_TOLERANCE_EN defined, lane mismatches iff |ofm - gold| > tolerance, difference in DATA_WIDTH+1 signed bits; undefined, mismatch iff bitwise unequal and tolerance port unused.

Structure
REQ-027 FSM state enum, RD_LATENCY bounds, counter widths SHALL live in shared package accel_cmp_pkg.
REQ-028 Per-lane compare+mask+popcount SHALL be sub-module ofm_lane_cmp, instantiated once per word.

Verification
REQ-029 26x26x15, LANES=16, data equal -> 634 reads (addr 0..633), last word 12 lanes valid, pass=1, err_count=0.
REQ-030 Same, gold element 500 off by 3, stop_on_err=0 -> err_count=1, first_err_idx=500, pass=0; with TOLERANCE_EN, tolerance=3 -> pass=1.
REQ-031 Mismatches at elements 40 and 9000, stop_on_err=1 -> issue stops within RD_LATENCY+1 cycles of word 2, err_count=1, first_err_idx=40.
REQ-032 Mismatch in masked lane 13 of word 633 -> ignored, pass=1.
REQ-033 RD_LATENCY=3, rst_n low at cycle 100 of pass -> no done, outputs 0; new start completes normally.
REQ-034 num_filter=0 -> no reads, done 2 cycles after start, pass=1; start pulsed while busy -> ignored.
